// File: rtl/unroller_pkg.sv
// Constants and helpers shared by the activation-side lane roll/unroll blocks.
package unroller_pkg;

  // Counter width for an n-state counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unroller.sv
// Gathers BEATS narrow beats of ROLL_NUM lanes into one registered NUM-lane vector.
// Beat 0 fills the lowest lanes; the final beat bypasses the buffer into the top lanes.
module unroller
  import unroller_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM        = 4,
  parameter int ROLL_NUM   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [ROLL_NUM],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [NUM],
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int BEATS = NUM / ROLL_NUM;
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if (NUM % ROLL_NUM != 0) begin : g_bad_cfg
    $error("unroller: NUM (%0d) must be a multiple of ROLL_NUM (%0d)", NUM, ROLL_NUM);
  end

  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] out_q [NUM];
  logic [DATA_WIDTH-1:0] out_d [NUM];
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] vec [NUM];
  logic                  is_last;
  logic                  in_fire;

  assign is_last       = (beat_cnt_q == LAST_CNT);
  // Stall only the closing beat, and only when the output slot cannot free up this cycle.
  assign data_in_ready = !is_last || !out_vld_q || data_out_ready;
  assign in_fire       = data_in_valid && data_in_ready;

  if (BEATS > 1) begin : g_buf
    localparam int GL = (BEATS - 1) * ROLL_NUM;

    logic [DATA_WIDTH-1:0] gbuf_q [GL];
    logic [DATA_WIDTH-1:0] gbuf_d [GL];

    always_comb begin
      gbuf_d = gbuf_q;
      if (in_fire && !is_last) begin
        for (int b = 0; b < BEATS - 1; b++) begin
          if (beat_cnt_q == CNT_W'(b)) begin
            for (int r = 0; r < ROLL_NUM; r++) gbuf_d[b*ROLL_NUM + r] = data_in[r];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) gbuf_q <= '{default: '0};
      else     gbuf_q <= gbuf_d;
    end

    always_comb begin
      vec = '{default: '0};
      for (int i = 0; i < GL; i++)       vec[i]      = gbuf_q[i];
      for (int r = 0; r < ROLL_NUM; r++) vec[GL + r] = data_in[r];
    end
  end else begin : g_nobuf
    always_comb begin
      vec = '{default: '0};
      for (int r = 0; r < ROLL_NUM; r++) vec[r] = data_in[r];
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    if (out_vld_q && data_out_ready) out_vld_d = 1'b0;
    // A load on the last beat overrides the drain, so back-to-back vectors see no bubble.
    if (in_fire) begin
      if (is_last) begin
        out_d      = vec;
        out_vld_d  = 1'b1;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      out_q      <= '{default: '0};
      out_vld_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign data_out       = out_q;
  assign data_out_valid = out_vld_q;

endmodule

// File: tb/tb_unroller.sv
// Bench for unroller: three configurations (4/1, 4/2, 2/2) against a beat-list model.
module tb_unroller;

  localparam int NUMC [3] = '{4, 4, 2};
  localparam int RLC  [3] = '{1, 2, 2};

  logic       clk, rst;
  logic [2:0] dv, dir, dov, dor;
  logic [7:0] din0 [1];
  logic [7:0] din1 [2];
  logic [7:0] din2 [2];
  logic [7:0] dout0 [4];
  logic [7:0] dout1 [4];
  logic [7:0] dout2 [2];

  logic [7:0] vin  [3][2];
  logic [7:0] vout [3][4];

  // Model: beats accepted so far in the current vector, and the last completed vector.
  int         part [3];
  logic [7:0] gath [3][4];
  logic [7:0] mvec [3][4];
  logic       mv   [3];

  int d_chk = 0, d_err = 0, m_chk = 0, m_err = 0;

  unroller #(.DATA_WIDTH(8), .NUM(4), .ROLL_NUM(1)) u0 (
    .clk(clk), .rst(rst), .data_in(din0), .data_in_valid(dv[0]), .data_in_ready(dir[0]),
    .data_out(dout0), .data_out_valid(dov[0]), .data_out_ready(dor[0]));
  unroller #(.DATA_WIDTH(8), .NUM(4), .ROLL_NUM(2)) u1 (
    .clk(clk), .rst(rst), .data_in(din1), .data_in_valid(dv[1]), .data_in_ready(dir[1]),
    .data_out(dout1), .data_out_valid(dov[1]), .data_out_ready(dor[1]));
  unroller #(.DATA_WIDTH(8), .NUM(2), .ROLL_NUM(2)) u2 (
    .clk(clk), .rst(rst), .data_in(din2), .data_in_valid(dv[2]), .data_in_ready(dir[2]),
    .data_out(dout2), .data_out_valid(dov[2]), .data_out_ready(dor[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    vin  = '{default: '0};
    vout = '{default: '0};
    vin[0][0] = din0[0];
    vin[1][0] = din1[0];
    vin[1][1] = din1[1];
    vin[2][0] = din2[0];
    vin[2][1] = din2[1];
    for (int j = 0; j < 4; j++) begin
      vout[0][j] = dout0[j];
      vout[1][j] = dout1[j];
    end
    for (int j = 0; j < 2; j++) vout[2][j] = dout2[j];
  end

  function automatic int bad8(string nm, int g, logic [7:0] a, logic [7:0] e);
    if (a !== e) begin
      $display("FAIL %s (dut%0d): got %02h, expected %02h", nm, g, a, e);
      return 1;
    end
    return 0;
  endfunction

  function automatic int bad1(string nm, int g, logic a, logic e);
    if (a !== e) begin
      $display("FAIL %s (dut%0d): got %b, expected %b", nm, g, a, e);
      return 1;
    end
    return 0;
  endfunction

  // Compare on the falling edge, then advance the model by what the next rising edge accepts.
  always @(negedge clk) begin
    int beats;
    bit er, ifire, ofire, load;
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        part[g] = 0;
        mv[g]   = 1'b0;
        for (int j = 0; j < 4; j++) begin
          gath[g][j] = 8'h00;
          mvec[g][j] = 8'h00;
        end
      end else begin
        beats = NUMC[g] / RLC[g];
        er    = (part[g] != beats - 1) || !mv[g] || dor[g];
        m_chk++; m_err += bad1("in_ready", g, dir[g], er);
        m_chk++; m_err += bad1("out_valid", g, dov[g], mv[g]);
        for (int j = 0; j < NUMC[g]; j++) begin
          m_chk++; m_err += bad8("out_lane", g, vout[g][j], mvec[g][j]);
        end
        ifire = dv[g] && er;
        ofire = mv[g] && dor[g];
        load  = 1'b0;
        if (ifire) begin
          for (int r = 0; r < RLC[g]; r++) gath[g][part[g]*RLC[g] + r] = vin[g][r];
          part[g]++;
          if (part[g] == beats) begin
            mvec[g] = gath[g];
            part[g] = 0;
            load    = 1'b1;
          end
        end
        mv[g] = (mv[g] && !ofire) || load;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dc1(string nm, int g, logic a, logic e);
    d_chk++;
    d_err += bad1(nm, g, a, e);
  endtask

  task automatic dc8(string nm, int g, logic [7:0] a, logic [7:0] e);
    d_chk++;
    d_err += bad8(nm, g, a, e);
  endtask

  task automatic send0(input logic [7:0] b);
    din0[0] = b;
    dv[0]   = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] bg [4];
    rst = 1'b1; dv = '0; dor = 3'b111;
    din0[0] = '0; din1 = '{default: '0}; din2 = '{default: '0};
    repeat (2) tick();
    dc1("rst_valid", 0, dov[0], 1'b0);
    dc1("rst_ready", 0, dir[0], 1'b1);
    for (int j = 0; j < 4; j++) dc8("rst_lane", 0, dout0[j], 8'h00);
    rst = 1'b0;

    // Basic gather
    bg = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      send0(bg[i]);
      if (i < 3) dc1("basic_early_valid", 0, dov[0], 1'b0);
    end
    dv[0] = 1'b0;
    dc1("basic_valid", 0, dov[0], 1'b1);
    for (int j = 0; j < 4; j++) dc8("basic_lane", 0, dout0[j], bg[j]);
    dc8("model_pin_lane3", 0, mvec[0][3], 8'h44);
    dc8("model_pin_lane0", 0, mvec[0][0], 8'h11);
    tick();
    dc1("basic_one_cycle", 0, dov[0], 1'b0);
    dc8("basic_hold", 0, dout0[3], 8'h44);

    // Backpressure: hold vector 01..04, then stream A1..A4
    dor[0] = 1'b0;
    for (int i = 1; i <= 4; i++) send0(8'(i));
    for (int i = 1; i <= 3; i++) begin
      din0[0] = 8'hA0 + 8'(i); dv[0] = 1'b1; #1;
      dc1("bp_accept", 0, dir[0], 1'b1);
      tick();
    end
    din0[0] = 8'hA4; dv[0] = 1'b1; #1;
    dc1("bp_stall", 0, dir[0], 1'b0);
    repeat (2) tick();
    dc1("bp_hold_valid", 0, dov[0], 1'b1);
    dc8("bp_hold_lane3", 0, dout0[3], 8'h04);
    dc8("bp_hold_lane0", 0, dout0[0], 8'h01);
    dor[0] = 1'b1; #1;
    dc1("bp_release", 0, dir[0], 1'b1);
    tick();
    dv[0] = 1'b0;
    dc1("bp_new_valid", 0, dov[0], 1'b1);
    for (int j = 0; j < 4; j++) dc8("bp_new_lane", 0, dout0[j], 8'hA1 + 8'(j));
    tick();
    dc1("bp_drained", 0, dov[0], 1'b0);

    // Sustained stream 00..0F
    for (int i = 0; i < 16; i++) begin
      din0[0] = 8'(i); dv[0] = 1'b1; #1;
      dc1("sus_ready", 0, dir[0], 1'b1);
      tick();
      dc1("sus_valid", 0, dov[0], (i % 4) == 3);
    end
    dv[0] = 1'b0;
    for (int j = 0; j < 4; j++) dc8("sus_last_lane", 0, dout0[j], 8'h0C + 8'(j));

    // Reset mid-gather
    send0(8'h55);
    send0(8'h66);
    dv[0] = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    dc1("mid_rst_valid", 0, dov[0], 1'b0);
    dc1("mid_rst_ready", 0, dir[0], 1'b1);
    for (int i = 1; i <= 4; i++) begin
      send0(8'(i));
      if (i < 4) dc1("mid_rst_early", 0, dov[0], 1'b0);
    end
    dv[0] = 1'b0;
    dc1("mid_rst_out_valid", 0, dov[0], 1'b1);
    for (int j = 0; j < 4; j++) dc8("mid_rst_lane", 0, dout0[j], 8'h01 + 8'(j));

    // ROLL_NUM=2 gather and BEATS=1 pass-through
    din1 = '{8'h01, 8'h02}; dv[1] = 1'b1;
    tick();
    din1 = '{8'h03, 8'h04};
    tick();
    dv[1] = 1'b0;
    dc1("r2_valid", 1, dov[1], 1'b1);
    for (int j = 0; j < 4; j++) dc8("r2_lane", 1, dout1[j], 8'h01 + 8'(j));
    din2 = '{8'hAA, 8'hBB}; dv[2] = 1'b1;
    tick();
    dv[2] = 1'b0;
    dc1("b1_latency", 2, dov[2], 1'b1);
    dc8("b1_lane0", 2, dout2[0], 8'hAA);
    dc8("b1_lane1", 2, dout2[1], 8'hBB);

    // Random traffic on all configurations, with rare resets
    repeat (1500) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int g = 0; g < 3; g++) begin
        dv[g]  = ($urandom_range(0, 3) != 0);
        dor[g] = ($urandom_range(0, 2) != 0);
      end
      din0[0] = 8'($urandom);
      din1[0] = 8'($urandom); din1[1] = 8'($urandom);
      din2[0] = 8'($urandom); din2[1] = 8'($urandom);
      tick();
    end
    rst = 1'b0; dv = '0; dor = 3'b111;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", d_chk + m_chk, d_err + m_err);
    $finish;
  end

endmodule
